uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter attached as a secondary on the system bus next to main memory. Consumes store transactions issued by the core, buffers bytes in a small FIFO, and serialises them 8N1 on a single `tx` line. Provides status and a programmable baud divisor so firmware under test can emit console output.

## Interface
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥2.
- `DIV_RESET`, 16'd433: reset value of DIVISOR. Bit period = DIVISOR+1 clocks.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input 1: bus access strobe for this device, one cycle per access.
- `we` input 1: 1 = write, 0 = read; sampled with `req`.
- `addr` input 2: word offset (0 TXDATA, 1 STATUS, 2 DIVISOR, 3 reserved).
- `wdata` input 32: write data.
- `rdata` output 32: read data, valid when `ack`=1.
- `ack` output 1: one-cycle completion pulse.
- `tx` output 1: serial output, idle high.
- `irq` output 1: transmit-idle interrupt (see Configuration).

## Operation
- Registers:
  - TXDATA (0, W): push `wdata[7:0]`. Reads return 0.
  - STATUS (1, R/W): bit0 full, bit1 empty, bit2 busy (shifter active), bit3 overflow (sticky), bit4 IE. Write 1 to bit3 clears it. Bits [31:5] read 0.
  - DIVISOR (2, R/W): bits[15:0]; upper bits read 0, writes ignored.
  - Reserved (3): reads 0, writes ignored.
- FIFO: circular, pointers wrap modulo `FIFO_DEPTH`; count width log2(DEPTH)+1.
  - Push when full with no pop that cycle: byte dropped, overflow set.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Push to empty FIFO while idle: byte enters FIFO, popped next cycle.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1; if FIFO non-empty, pop into shift register, latch DIVISOR, go START.
  - START: `tx`=0 for one bit period.
  - DATA: 8 bits LSB first, one bit period each, bit index 0..7.
  - STOP: `tx`=1 for one bit period, then IDLE.
  - busy = state ≠ IDLE.
- DIVISOR writes during a frame affect the next frame only. DIVISOR=0 gives 1-clock bits.

## Timing
- Reset values: `rdata`=0, `ack`=0, `tx`=1, `irq`=0, FIFO empty, overflow=0, IE=0, DIVISOR=`DIV_RESET`, state IDLE.
- `ack` asserted exactly one cycle after `req`, for one cycle; `rdata` registered, valid with `ack`, 0 otherwise.
- Write side effects (push, clears, divisor) take effect at the `clk` edge that samples `req`.
- STATUS read reflects state at the sampling edge.
- Start bit begins 1 cycle after a pop from IDLE; the pop happens on the first edge in IDLE with FIFO non-empty.
- Frame = 10 × (DIVISOR+1) clocks; back-to-back frames: IDLE lasts exactly 1 cycle between STOP and next START.
- Reset mid-frame: `tx` forced to 1 immediately (asynchronously), FIFO flushed, frame abandoned.
- `req` while `ack` high is legal; each `req` gets its own `ack`.

## Configuration
- `UART_TX_IRQ_EN` defined: STATUS bit4 IE is writable; `irq` = IE & empty & ~busy, registered (1-cycle lag).
- Not defined: bit4 reads 0, writes ignored; `irq` tied to 0. Port list is unchanged.

## Test plan
- Reset then read STATUS -> `rdata`=0x00000002, DIVISOR read -> 433, `tx`=1.
- DIVISOR=3, write TXDATA 0x55 -> `tx` low for 4 clocks, then 1,0,1,0,1,0,1,0 each 4 clocks, then high 4 clocks; busy cleared after 40 clocks.
- DIVISOR=0, push 0xA1,0xB2,0xC3,0xD4,0xE5 back-to-back while first frame active -> all five bytes transmitted in order, overflow stays 0 (first pop frees a slot); a sixth/seventh push while full -> overflow=1, byte dropped; write STATUS 0x8 -> overflow=0.
- Write DIVISOR=1 mid-frame of 0x0F at DIVISOR=3 -> current frame keeps 4-clock bits, next frame uses 2-clock bits.
- Assert `rst` during DATA bit 3 -> `tx`=1 same cycle, STATUS=0x2 after release, no further bits.
- With `UART_TX_IRQ_EN`: IE=1, send 0x42 -> `irq`=0 while busy, `irq`=1 one cycle after return to IDLE with empty FIFO; without macro `irq` stays 0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter for console output from firmware.
// Bytes written to TXDATA are queued in a small circular FIFO and shifted
// out LSB first on tx. Each bit lasts DIVISOR+1 clocks.
//
// Register map (word offsets):
//   0 TXDATA  (W)   push wdata[7:0]; reads return 0
//   1 STATUS  (R/W) bit0 full, bit1 empty, bit2 busy, bit3 overflow (W1C),
//                   bit4 IE
//   2 DIVISOR (R/W) bits[15:0]
//   3 reserved      reads 0, writes ignored
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   req, we    single-cycle access strobe and write enable
//   addr       word offset
//   wdata      write data
//   rdata, ack registered read data and one-cycle completion pulse
//   tx         serial output, idle high
//   irq        transmit-idle interrupt
//
// Build option: define UART_TX_IRQ_EN to make STATUS.IE writable and drive
// irq = IE & empty & ~busy (registered). Without it IE reads 0 and irq is 0.
module uart_tx_mmio #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        tx,
  output logic        irq
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic [15:0]   divisor;
  logic [15:0]   div_lat;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          ovf;
  logic          ie;

  logic          full;
  logic          empty;
  logic          busy;
  logic          bit_done;
  logic          pop;
  logic          wr_data;
  logic          wr_status;
  logic          wr_div;
  logic          push_ok;
  logic          push_drop;
  logic [31:0]   rd_val;
  logic          unused_wdata;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign bit_done  = (baud_cnt == div_lat);
  assign pop       = (state == IDLE) && !empty;

  assign wr_data   = req && we && (addr == 2'd0);
  assign wr_status = req && we && (addr == 2'd1);
  assign wr_div    = req && we && (addr == 2'd2);
  // A push into a full FIFO still lands if the shifter frees a slot the
  // same cycle; only a push with no simultaneous pop is dropped.
  assign push_ok   = wr_data && (!full || pop);
  assign push_drop = wr_data && full && !pop;

  assign unused_wdata = ^wdata[31:16];

  // ---- bus register file and read path ----
  always_comb begin
    rd_val = 32'd0;
    case (addr)
      2'd1:    rd_val = {27'd0, ie, ovf, busy, empty, full};
      2'd2:    rd_val = {16'd0, divisor};
      default: rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack     <= 1'b0;
      rdata   <= 32'd0;
      divisor <= DIV_RESET;
      ovf     <= 1'b0;
    end else begin
      ack     <= req;
      rdata   <= (req && !we) ? rd_val : 32'd0;
      if (wr_div) divisor <= wdata[15:0];
      if (push_drop)                   ovf <= 1'b1;
      else if (wr_status && wdata[3])  ovf <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_status) ie <= wdata[4];
      irq <= ie && empty && !busy;
    end
  end
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  // ---- transmit FIFO ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end

  // Storage and shift data carry no reset; control decides when they matter.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata[7:0];
    if (pop) begin
      shreg   <= mem[rptr];
      div_lat <= divisor;
    end else if ((state == DATA) && bit_done) begin
      shreg   <= {1'b0, shreg[7:1]};
    end
  end

  // ---- serialiser ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty)                        state_nxt = START;
      START:   if (bit_done)                      state_nxt = DATA;
      DATA:    if (bit_done && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:    if (bit_done)                      state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else if (pop) begin
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
    end else if (busy) begin
      if (bit_done) begin
        baud_cnt <= 16'd0;
        if (state == DATA) bit_idx <= bit_idx + 3'd1;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

  // tx is decoded straight from state so reset forces it high immediately.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ack;
  logic        tx;
  logic        irq;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

`ifdef UART_TX_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of pending bytes plus the current frame
  // described by its start time, byte and divisor.
  logic [7:0]  mq[$];
  bit          m_active = 1'b0;
  int          m_t = 0;
  int          m_fdiv = 0;
  logic [7:0]  m_fbyte = 8'd0;
  bit          m_ovf = 1'b0;
  bit          m_ie = 1'b0;
  logic [15:0] m_div = 16'd433;
  bit          m_ack = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  bit          m_irq = 1'b0;
  logic [7:0]  sent_log[$];
  int          div_log[$];

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd1: return {27'd0, m_ie, m_ovf, m_active, (mq.size() == 0), (mq.size() == DEPTH)};
      2'd2: return {16'd0, m_div};
      default: return 32'd0;
    endcase
  endfunction

  // Line level at time t into a frame: bit slot t/(div+1); slot 0 start,
  // 1..8 data LSB first, 9 stop.
  function automatic logic m_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / (m_fdiv + 1);
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return m_fbyte[b-1];
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit pop, full, empty, busy;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
      m_ie     = 1'b0;
      m_div    = 16'd433;
      m_ack    = 1'b0;
      m_rdata  = 32'd0;
      m_irq    = 1'b0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      busy  = m_active;
      pop   = !m_active && !empty;
      m_ack   = req;
      m_rdata = (req && !we) ? m_read(addr) : 32'd0;
      if (IRQ_BUILD) m_irq = m_ie && empty && !busy;
      if (m_active) begin
        m_t++;
        if (m_t == 10 * (m_fdiv + 1)) m_active = 1'b0;
      end
      if (pop) begin
        m_fbyte  = mq.pop_front();
        m_fdiv   = int'(m_div);
        m_active = 1'b1;
        m_t      = 0;
        sent_log.push_back(m_fbyte);
        div_log.push_back(m_fdiv);
      end
      if (req && we) begin
        case (addr)
          2'd0: if (full && !pop) m_ovf = 1'b1; else mq.push_back(wdata[7:0]);
          2'd1: begin
            if (wdata[3]) m_ovf = 1'b0;
            if (IRQ_BUILD) m_ie = wdata[4];
          end
          2'd2: m_div = wdata[15:0];
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("tx", {31'd0, tx}, {31'd0, m_tx()});
      chk("ack", {31'd0, ack}, {31'd0, m_ack});
      chk("rdata", rdata, m_rdata);
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // Call only at a falling edge; returns at the falling edge where ack shows.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus(1'b0, a, 32'd0);
    d = rdata;
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  pat55;
    logic [7:0]  exp5 [5];
    int          r;
    pat55 = 10'b10_1010_1010;
    exp5  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    started = 1'b1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rd(2'd1, d); chk("rst_status", d, 32'h2);
    rd(2'd2, d); chk("rst_div", d, 32'd433);

    // 0x55 at DIVISOR=3
    bus(1'b1, 2'd2, 32'hABCD_0003);
    rd(2'd2, d); chk("div_upper_ignored", d, 32'd3);
    bus(1'b1, 2'd0, 32'h0000_0055);
    chk("pre_start_tx", {31'd0, tx}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("frame55", {31'd0, tx}, {31'd0, pat55[i/4]});
    end
    @(negedge clk);
    rd(2'd1, d); chk("idle_after_55", d, 32'h2);
    rd(2'd0, d); chk("txdata_reads0", d, 32'd0);
    bus(1'b1, 2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d); chk("reserved_reads0", d, 32'd0);

    // Back-to-back bytes at DIVISOR=0, overflow and clear
    bus(1'b1, 2'd2, 32'd0);
    sent_log.delete();
    bus(1'b1, 2'd0, 32'hA1);
    bus(1'b1, 2'd0, 32'hB2);
    bus(1'b1, 2'd0, 32'hC3);
    bus(1'b1, 2'd0, 32'hD4);
    bus(1'b1, 2'd0, 32'hE5);
    rd(2'd1, d); chk("full_no_ovf", d, 32'h5);
    bus(1'b1, 2'd0, 32'hF6);
    bus(1'b1, 2'd0, 32'h07);
    rd(2'd1, d); chk("ovf_set", d, 32'hD);
    bus(1'b1, 2'd1, 32'h8);
    rd(2'd1, d); chk("ovf_cleared", d, 32'h5);
    repeat (70) @(negedge clk);
    chk("sent_count5", sent_log.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < sent_log.size()) chk("sent_order", {24'd0, sent_log[i]}, {24'd0, exp5[i]});
    rd(2'd1, d); chk("drained", d, 32'h2);

    // DIVISOR change mid-frame applies to next frame only
    bus(1'b1, 2'd2, 32'd3);
    sent_log.delete();
    div_log.delete();
    bus(1'b1, 2'd0, 32'h0F);
    repeat (10) @(negedge clk);
    bus(1'b1, 2'd2, 32'd1);
    bus(1'b1, 2'd0, 32'h33);
    repeat (80) @(negedge clk);
    chk("div_frames", div_log.size(), 32'd2);
    if (div_log.size() == 2) begin
      chk("div_first", div_log[0], 32'd3);
      chk("div_second", div_log[1], 32'd1);
    end

    // Reset during DATA bit 3 of 0xF0 (bit3 = 0)
    bus(1'b1, 2'd2, 32'd3);
    bus(1'b1, 2'd0, 32'hF0);
    bus(1'b1, 2'd0, 32'h77);
    repeat (17) @(negedge clk);
    chk("bit3_low", {31'd0, tx}, 32'd0);
    #2 rst = 1'b1;
    #1 chk("rst_async_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(2'd1, d); chk("status_after_rst", d, 32'h2);
    repeat (40) @(negedge clk);
    chk("no_bits_after_rst", {31'd0, tx}, 32'd1);

    // Interrupt behaviour
    bus(1'b1, 2'd2, 32'd2);
    bus(1'b1, 2'd1, 32'h10);
    rd(2'd1, d); chk("ie_readback", d, IRQ_BUILD ? 32'h12 : 32'h02);
    chk("irq_idle", {31'd0, irq}, {31'd0, IRQ_BUILD});
    bus(1'b1, 2'd0, 32'h42);
    repeat (5) @(negedge clk);
    chk("irq_busy", {31'd0, irq}, 32'd0);
    repeat (26) @(negedge clk);
    chk("irq_stop_edge", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_after_idle", {31'd0, irq}, {31'd0, IRQ_BUILD});

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 19);
      if (r < 3) bus(1'b1, 2'd0, $urandom);
      else if (r < 6) bus(1'b0, 2'($urandom_range(0, 3)), 32'd0);
      else if (r == 6) bus(1'b1, 2'd1, $urandom);
      else if (r == 7) begin
        d = $urandom;
        d[15:0] = 16'($urandom_range(0, 3));
        bus(1'b1, 2'd2, d);
      end else if (r == 8) bus(1'b1, 2'd3, $urandom);
      else @(negedge clk);
    end
    repeat (300) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
